// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32 pipeline stages and pipeline_hazard_ctrl.
// The master side is the pipeline; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if;
    logic        memread_EX;
    logic [4:0]  rd_EX;
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic        use_rs1_ID;
    logic        use_rs2_ID;
    logic        redirect_EX;
    logic        mdu_op_EX;
    logic        mdu_done;
    logic        dmem_req_MEM;
    logic        dmem_ready;
    logic        mdu_start;
    logic        stall_PC;
    logic        stall_IF_ID;
    logic        flush_IF_ID;
    logic        stall_ID_EX;
    logic        flush_ID_EX;
    logic        stall_EX_MEM;
    logic        flush_EX_MEM;
    logic        flush_MEM_WB;
    logic        mem_err;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    modport master (
        output memread_EX, rd_EX, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
               redirect_EX, mdu_op_EX, mdu_done, dmem_req_MEM, dmem_ready,
        input  mdu_start, stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX,
               flush_ID_EX, stall_EX_MEM, flush_EX_MEM, flush_MEM_WB,
               mem_err, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  memread_EX, rd_EX, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
               redirect_EX, mdu_op_EX, mdu_done, dmem_req_MEM, dmem_ready,
        output mdu_start, stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX,
               flush_ID_EX, stall_EX_MEM, flush_EX_MEM, flush_MEM_WB,
               mem_err, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: dmem wait > MDU > redirect > load-use.
// Define HAZARD_PERF_EN to build the stall/redirect-flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   hz
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MDU_WAIT, MEM_WAIT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_pend_q, done_pend_d;
    logic          mdu_start_q, mdu_start_d;
    logic          mem_err_q, mem_err_d;
    logic          memstall, loaduse, redirect_flush;
    logic          s_pc, s_ifid, s_idex, s_exmem;
    logic          f_ifid, f_idex, f_exmem, f_memwb;

    assign memstall = hz.dmem_req_MEM & ~hz.dmem_ready;
    assign loaduse  = hz.memread_EX & (hz.rd_EX != 5'd0) &
                      ((hz.use_rs1_ID & (hz.rs1_ID == hz.rd_EX)) |
                       (hz.use_rs2_ID & (hz.rs2_ID == hz.rd_EX)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            done_pend_q <= 1'b0;
            mdu_start_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_pend_q <= done_pend_d;
            mdu_start_q <= mdu_start_d;
            mem_err_q   <= mem_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        done_pend_d    = done_pend_q;
        mdu_start_d    = 1'b0;
        mem_err_d      = mem_err_q;
        redirect_flush = 1'b0;
        s_pc = 1'b0; s_ifid = 1'b0; s_idex = 1'b0; s_exmem = 1'b0;
        f_ifid = 1'b0; f_idex = 1'b0; f_exmem = 1'b0; f_memwb = 1'b0;
        if (reset) begin
            f_ifid = 1'b1; f_idex = 1'b1; f_exmem = 1'b1; f_memwb = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (memstall) begin
                        s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1; s_exmem = 1'b1;
                        f_memwb = 1'b1;
                        state_d = MEM_WAIT;
                        cnt_d   = CW'(1);
                    end else if (hz.mdu_op_EX) begin
                        s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1;
                        f_exmem     = 1'b1;
                        mdu_start_d = 1'b1;
                        done_pend_d = 1'b0;
                        state_d     = MDU_WAIT;
                    end else if (hz.redirect_EX) begin
                        f_ifid = 1'b1; f_idex = 1'b1;
                        redirect_flush = 1'b1;
                    end else if (loaduse) begin
                        s_pc = 1'b1; s_ifid = 1'b1; f_idex = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (hz.mdu_done) done_pend_d = 1'b1;
                    // Release in the completion cycle so the MDU op advances out of EX.
                    if ((hz.mdu_done | done_pend_q) & ~memstall) begin
                        done_pend_d = 1'b0;
                        state_d     = RUN;
                    end else begin
                        s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1;
                        if (memstall) begin
                            s_exmem = 1'b1; f_memwb = 1'b1;
                        end else begin
                            f_exmem = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (memstall) begin
                        s_pc = 1'b1; s_ifid = 1'b1; s_idex = 1'b1; s_exmem = 1'b1;
                        f_memwb = 1'b1;
                        if (cnt_q != CW'(MEM_TIMEOUT)) cnt_d = cnt_q + 1'b1;
                        if (cnt_q >= CW'(MEM_TIMEOUT - 1)) mem_err_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign hz.mdu_start    = mdu_start_q;
    assign hz.mem_err      = mem_err_q;
    assign hz.stall_PC     = s_pc;
    assign hz.stall_IF_ID  = s_ifid;
    assign hz.flush_IF_ID  = f_ifid;
    assign hz.stall_ID_EX  = s_idex;
    assign hz.flush_ID_EX  = f_idex;
    assign hz.stall_EX_MEM = s_exmem;
    assign hz.flush_EX_MEM = f_exmem;
    assign hz.flush_MEM_WB = f_memwb;

`ifdef HAZARD_PERF_EN
    logic [31:0] pstall_q, pflush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pstall_q <= '0;
            pflush_q <= '0;
        end else begin
            if (s_pc)           pstall_q <= pstall_q + 32'd1;
            if (redirect_flush) pflush_q <= pflush_q + 32'd1;
        end
    end

    assign hz.perf_stall_cnt = pstall_q;
    assign hz.perf_flush_cnt = pflush_q;
`else
    assign hz.perf_stall_cnt = '0;
    assign hz.perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a rule-level reference model checked every cycle.
// Honours HAZARD_PERF_EN the same way as the design build.
module tb_pipeline_hazard_ctrl;
    localparam int T = 4;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output patterns: {stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX,
    //                   flush_ID_EX, stall_EX_MEM, flush_EX_MEM, flush_MEM_WB}
    localparam logic [7:0] P_RST   = 8'b0010_1011;
    localparam logic [7:0] P_MEM   = 8'b1101_0101;
    localparam logic [7:0] P_MDU   = 8'b1101_0010;
    localparam logic [7:0] P_REDIR = 8'b0010_1000;
    localparam logic [7:0] P_LU    = 8'b1100_1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz_if ();
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (.clk(clk), .reset(reset), .hz(hz_if));

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    bit          m_in_mem = 1'b0, m_in_mdu = 1'b0, m_done_seen = 1'b0;
    bit          m_start = 1'b0, m_err = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_pstall = '0, m_pflush = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_memstall();
        return hz_if.dmem_req_MEM && !hz_if.dmem_ready;
    endfunction

    function automatic bit m_loaduse();
        return hz_if.memread_EX && hz_if.rd_EX != 5'd0 &&
               ((hz_if.use_rs1_ID && hz_if.rs1_ID == hz_if.rd_EX) ||
                (hz_if.use_rs2_ID && hz_if.rs2_ID == hz_if.rd_EX));
    endfunction

    function automatic logic [7:0] exp_outs();
        bit ms;
        ms = m_memstall();
        if (reset) return P_RST;
        if (m_in_mem) return ms ? P_MEM : 8'h00;
        if (m_in_mdu) begin
            if ((hz_if.mdu_done || m_done_seen) && !ms) return 8'h00;
            return ms ? P_MEM : P_MDU;
        end
        if (ms) return P_MEM;
        if (hz_if.mdu_op_EX) return P_MDU;
        if (hz_if.redirect_EX) return P_REDIR;
        if (m_loaduse()) return P_LU;
        return 8'h00;
    endfunction

    // Reference model advances on the active edge; inputs change 1 time unit later.
    always @(posedge clk) begin : mdl
        logic [7:0] e;
        bit ms;
        e  = exp_outs();
        ms = m_memstall();
        if (reset) begin
            m_in_mem = 0; m_in_mdu = 0; m_done_seen = 0; m_start = 0; m_err = 0;
            m_wait = 0; m_pstall = '0; m_pflush = '0;
        end else begin
            if (e[7]) m_pstall = m_pstall + 32'd1;
            if (e == P_REDIR) m_pflush = m_pflush + 32'd1;
            m_start = 0;
            if (m_in_mem) begin
                if (ms) begin
                    if (m_wait < T) m_wait++;
                    if (m_wait >= T) m_err = 1;
                end else begin
                    m_in_mem = 0;
                    m_wait   = 0;
                end
            end else if (m_in_mdu) begin
                if (hz_if.mdu_done) m_done_seen = 1;
                if (m_done_seen && !ms) begin
                    m_in_mdu = 0;
                    m_done_seen = 0;
                end
            end else if (ms) begin
                m_in_mem = 1;
                m_wait   = 1;
            end else if (hz_if.mdu_op_EX) begin
                m_in_mdu = 1;
                m_start  = 1;
                m_done_seen = 0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [7:0] act;
        if (started) begin
            act = {hz_if.stall_PC, hz_if.stall_IF_ID, hz_if.flush_IF_ID, hz_if.stall_ID_EX,
                   hz_if.flush_ID_EX, hz_if.stall_EX_MEM, hz_if.flush_EX_MEM, hz_if.flush_MEM_WB};
            check("outs", {24'd0, act}, {24'd0, exp_outs()});
            check("mdu_start", hz_if.mdu_start, m_start);
            check("mem_err", hz_if.mem_err, m_err);
            check("perf_stall", hz_if.perf_stall_cnt, PERF ? m_pstall : 32'd0);
            check("perf_flush", hz_if.perf_flush_cnt, PERF ? m_pflush : 32'd0);
        end
    end

    task automatic clr();
        hz_if.memread_EX = 0; hz_if.rd_EX = '0; hz_if.rs1_ID = '0; hz_if.rs2_ID = '0;
        hz_if.use_rs1_ID = 0; hz_if.use_rs2_ID = 0; hz_if.redirect_EX = 0;
        hz_if.mdu_op_EX = 0; hz_if.mdu_done = 0; hz_if.dmem_req_MEM = 0; hz_if.dmem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1);
        hz_if.memread_EX = 1; hz_if.rd_EX = rd; hz_if.rs1_ID = rs1; hz_if.use_rs1_ID = u1;
    endtask

    initial begin
        reset = 1;
        clr();
        tick();
        started = 1;
        tick();
        #2;
        check("rst_flush_IF_ID", hz_if.flush_IF_ID, 1);
        check("rst_stall_PC", hz_if.stall_PC, 0);
        tick();
        reset = 0;

        // Load-use: one stall cycle, x0 never stalls
        set_lu(5'd5, 5'd5, 1'b1);
        #2;
        check("lu_stall_PC", hz_if.stall_PC, 1);
        check("lu_flush_ID_EX", hz_if.flush_ID_EX, 1);
        tick();
        clr();
        #2;
        check("lu_release", hz_if.stall_PC, 0);
        tick();
        set_lu(5'd0, 5'd0, 1'b1);
        #2;
        check("lu_x0", hz_if.stall_PC, 0);
        tick();
        set_lu(5'd7, 5'd7, 1'b0);
        hz_if.rs2_ID = 5'd7;
        tick();
        hz_if.use_rs2_ID = 1;
        tick();
        clr();
        hz_if.mdu_done = 1;
        tick();
        clr();
        tick();

        // Redirect beats load-use
        do_reset();
        set_lu(5'd5, 5'd5, 1'b1);
        hz_if.redirect_EX = 1;
        #2;
        check("redir_flush_IF_ID", hz_if.flush_IF_ID, 1);
        check("redir_stall_PC", hz_if.stall_PC, 0);
        tick();
        clr();
        #2;
        check("redir_perf_flush", hz_if.perf_flush_cnt, PERF ? 32'd1 : 32'd0);
        tick();

        // MDU sequence: start pulse, done five cycles after it
        do_reset();
        hz_if.mdu_op_EX = 1;
        #2;
        check("mdu_detect_stall", hz_if.stall_PC, 1);
        check("mdu_start_lat", hz_if.mdu_start, 0);
        tick();
        #2;
        check("mdu_start_pulse", hz_if.mdu_start, 1);
        tick();
        #2;
        check("mdu_start_end", hz_if.mdu_start, 0);
        check("mdu_wait_flush_EX_MEM", hz_if.flush_EX_MEM, 1);
        tick(); tick(); tick(); tick();
        hz_if.mdu_done = 1;
        #2;
        check("mdu_done_release", hz_if.stall_PC, 0);
        tick();
        clr();
        #2;
        check("mdu_perf_stall", hz_if.perf_stall_cnt, PERF ? 32'd6 : 32'd0);
        check("mdu_after_run", hz_if.stall_PC, 0);
        tick();

        // MDU op together with redirect: MDU wins, done right after start
        hz_if.mdu_op_EX = 1; hz_if.redirect_EX = 1;
        tick();
        hz_if.redirect_EX = 0; hz_if.mdu_done = 1;
        tick();
        clr();
        tick();

        // MDU done while an older dmem access is still waiting
        do_reset();
        hz_if.mdu_op_EX = 1;
        tick();
        tick();
        hz_if.dmem_req_MEM = 1;
        tick();
        hz_if.mdu_done = 1;
        #2;
        check("mdumem_stall_EX_MEM", hz_if.stall_EX_MEM, 1);
        check("mdumem_flush_EX_MEM", hz_if.flush_EX_MEM, 0);
        tick();
        hz_if.mdu_done = 0;
        #2;
        check("mdumem_hold", hz_if.stall_PC, 1);
        tick();
        hz_if.dmem_ready = 1;
        #2;
        check("mdumem_release", hz_if.stall_PC, 0);
        tick();
        clr();
        #2;
        check("mdumem_run", hz_if.stall_PC, 0);
        tick();

        // Memory timeout with MEM_TIMEOUT=4
        do_reset();
        hz_if.dmem_req_MEM = 1;
        for (int i = 1; i <= 6; i++) begin
            #2;
            if (i == 4) check("memto_before", hz_if.mem_err, 0);
            if (i == 5) check("memto_set", hz_if.mem_err, 1);
            tick();
        end
        hz_if.dmem_ready = 1;
        #2;
        check("memto_release", hz_if.stall_PC, 0);
        check("memto_sticky", hz_if.mem_err, 1);
        tick();
        clr();
        hz_if.redirect_EX = 1;
        #2;
        check("memto_redir_after", hz_if.flush_IF_ID, 1);
        tick();
        clr();
        reset = 1;
        tick();
        #2;
        check("memto_reset_clear", hz_if.mem_err, 0);
        reset = 0;
        tick();

        // Reset in the middle of an MDU wait
        hz_if.mdu_op_EX = 1;
        tick();
        clr();
        reset = 1;
        #2;
        check("rstmdu_flush_ID_EX", hz_if.flush_ID_EX, 1);
        check("rstmdu_flush_MEM_WB", hz_if.flush_MEM_WB, 1);
        check("rstmdu_stall_EX_MEM", hz_if.stall_EX_MEM, 0);
        tick();
        reset = 0;
        #2;
        check("rstmdu_no_start", hz_if.mdu_start, 0);
        check("rstmdu_run", hz_if.stall_PC, 0);
        tick();
        #2;
        check("rstmdu_no_start2", hz_if.mdu_start, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
